// File: rtl/imm_ext_pkg.sv
// Shared definitions for the LEGv8 immediate-extension pipe: mode encoding
// and instruction field positions.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    ZIMM12   = 3'd0,
    SDT9     = 3'd1,
    SBR26    = 3'd2,
    SCB19    = 3'd3,
    MOVZ     = 3'd4,
    SHAMT6   = 3'd5,
    ILLEGAL6 = 3'd6,
    ILLEGAL7 = 3'd7
  } mode_e;

  localparam int ZIMM_LSB  = 10;
  localparam int ZIMM_MSB  = 21;
  localparam int SDT_LSB   = 12;
  localparam int SDT_MSB   = 20;
  localparam int BR_LSB    = 0;
  localparam int BR_MSB    = 25;
  localparam int CB_LSB    = 5;
  localparam int CB_MSB    = 23;
  localparam int MOV_LSB   = 5;
  localparam int MOV_MSB   = 20;
  localparam int HW_LSB    = 21;
  localparam int HW_MSB    = 22;
  localparam int SHAMT_LSB = 10;
  localparam int SHAMT_MSB = 15;

  // Extension is formed at this width, then truncated to OUT_WIDTH.
  localparam int FULL_W = 64;

endpackage

// File: rtl/imm_ext_buf.sv
// Two-entry FIFO with registered ready/valid; the head entry drives dout.
module imm_ext_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              live;
  logic              push, pop;

  // live holds in_ready low until the first edge after reset releases.
  assign in_ready  = live && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign dout      = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate extender: combinational extension at the input, results
// buffered in a 2-entry FIFO so the output is always registered.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 err
);

  logic [FULL_W-1:0]  ext_full;
  logic               ext_err;
  logic [OUT_WIDTH:0] buf_din, buf_dout;
  logic               unused_instr;

  assign unused_instr = ^instr[31:26];

  always_comb begin
    ext_full = '0;
    ext_err  = 1'b0;
    case (mode_e'(mode))
      ZIMM12: ext_full = FULL_W'(instr[ZIMM_MSB:ZIMM_LSB]);
      SDT9:   ext_full = {{(FULL_W-(SDT_MSB-SDT_LSB+1)){instr[SDT_MSB]}},
                          instr[SDT_MSB:SDT_LSB]};
      SBR26:  ext_full = {{(FULL_W-(BR_MSB-BR_LSB+3)){instr[BR_MSB]}},
                          instr[BR_MSB:BR_LSB], 2'b00};
      SCB19:  ext_full = {{(FULL_W-(CB_MSB-CB_LSB+3)){instr[CB_MSB]}},
                          instr[CB_MSB:CB_LSB], 2'b00};
      // Shift of 16*hw; bits pushed past FULL_W fall off, truncation handles OUT_WIDTH.
      MOVZ:   ext_full = FULL_W'(instr[MOV_MSB:MOV_LSB]) << {instr[HW_MSB:HW_LSB], 4'b0000};
      SHAMT6: ext_full = FULL_W'(instr[SHAMT_MSB:SHAMT_LSB]);
      default: begin
        ext_full = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  assign buf_din = {ext_err, ext_full[OUT_WIDTH-1:0]};

  imm_ext_buf #(.W(OUT_WIDTH + 1)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (buf_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (buf_dout)
  );

  assign out = buf_dout[OUT_WIDTH-1:0];
  assign err = buf_dout[OUT_WIDTH];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized self-checking bench for imm_extend_pipe against a queue-based
// reference of the extension rules and FIFO behaviour.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [2:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] q[$];
  bit          init = 0;
  bit          last_in_fire;
  int          npop = 0;

  imm_extend_pipe #(.OUT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ref_ext(input logic [2:0] m, input logic [31:0] i);
    longint unsigned v;
    logic e;
    e = 1'b0;
    case (m)
      3'd0: v = (i >> 10) & 32'hFFF;
      3'd1: begin v = (i >> 12) & 32'h1FF;   if (v >= 256)   v = v - 512;   end
      3'd2: begin v = i & 32'h3FFFFFF;        if (v >= 2**25) v = v - 2**26; v = v * 4; end
      3'd3: begin v = (i >> 5) & 32'h7FFFF;  if (v >= 2**18) v = v - 2**19; v = v * 4; end
      3'd4: v = ((i >> 5) & 32'hFFFF) * (64'd1 << (16 * ((i >> 21) & 3)));
      3'd5: v = (i >> 10) & 32'h3F;
      default: begin v = 0; e = 1'b1; end
    endcase
    return {e, v};
  endfunction

  // One clock: check outputs against the model, advance the model on the edge.
  task automatic cycle();
    bit fin, fout;
    logic [64:0] item;
    chk("in_ready", {64'd0, in_ready}, {64'd0, (init && q.size() < 2)});
    chk("out_valid", {64'd0, out_valid}, {64'd0, (q.size() > 0)});
    if (q.size() > 0) chk("out_data", {err, out}, q[0]);
    fin  = in_valid && init && (q.size() < 2);
    fout = out_ready && (q.size() > 0);
    item = ref_ext(mode, instr);
    @(posedge clk);
    if (fout) begin void'(q.pop_front()); npop++; end
    if (fin) q.push_back(item);
    if (reset) init = 1;
    last_in_fire = fin;
    @(negedge clk);
  endtask

  task automatic directed(input logic [2:0] m, input logic [31:0] i,
                          input logic [63:0] eo, input logic ee);
    mode = m; instr = i; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("dir_valid", {64'd0, out_valid}, 65'd1);
    chk("dir_out", {err, out}, {ee, eo});
    cycle();
  endtask

  initial begin
    int n, guard, pops0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_out", {err, out}, 65'd0);
    reset = 1'b1;
    cycle();
    chk("ready_after_rst", {64'd0, in_ready}, 65'd1);

    directed(3'd0, 32'h003FFC00, 64'h0000000000000FFF, 1'b0);
    directed(3'd1, 32'h001F8000, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    directed(3'd2, 32'h03FFFFFF, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    directed(3'd4, 32'h0077DDE0, 64'hBEEF000000000000, 1'b0);
    directed(3'd7, 32'h12345678, 64'h0, 1'b1);

    // Backpressure: A, B accepted, C held until a slot frees.
    out_ready = 1'b0; in_valid = 1'b1;
    mode = 3'd3; instr = 32'h00800020; cycle();
    mode = 3'd5; instr = 32'h0000FC00; cycle();
    mode = 3'd0; instr = 32'hABCDEF01; cycle();
    chk("bp_full", {64'd0, in_ready}, 65'd0);
    chk("bp_depth", 65'(q.size()), 65'd2);
    out_ready = 1'b1;
    guard = 0;
    do begin cycle(); guard++; end while (!last_in_fire && guard < 10);
    chk("bp_c_accept", {64'd0, last_in_fire}, 65'd1);
    in_valid = 1'b0;
    repeat (3) cycle();

    // Streaming: 10 back-to-back items, never more than one buffered.
    pops0 = npop;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mode = 3'($urandom_range(0, 5)); instr = $urandom;
      cycle();
      chk("stream_fire", {64'd0, last_in_fire}, 65'd1);
      chk("stream_depth", {64'd0, (q.size() <= 1)}, 65'd1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_count", 65'(npop - pops0), 65'd10);

    // Random traffic.
    n = 0;
    mode = 3'($urandom_range(0, 7)); instr = $urandom;
    in_valid = 1'($urandom); out_ready = 1'($urandom);
    repeat (400) begin
      cycle();
      if (last_in_fire || !in_valid) begin
        mode = 3'($urandom_range(0, 7)); instr = $urandom;
        in_valid = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset with two items buffered.
    out_ready = 1'b0; in_valid = 1'b1;
    mode = 3'd1; instr = $urandom; cycle();
    mode = 3'd2; instr = $urandom; cycle();
    in_valid = 1'b0;
    chk("pre_rst_depth", 65'(q.size()), 65'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_out_valid", {64'd0, out_valid}, 65'd0);
    chk("async_in_ready", {64'd0, in_ready}, 65'd0);
    chk("async_out", {err, out}, 65'd0);
    q.delete(); init = 0;
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    repeat (4) cycle();
    directed(3'd5, 32'h00003C00, 64'h000000000000000F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
